// File: rtl/rr_lock_burst_ctrl.sv
// rr_lock_burst_ctrl
// Sequencing controller placed beside a lockable round-robin arbiter. It
// watches the arbiter output handshake, holds the arbiter's round-robin
// pointer (lock_rr_o) for the whole of a multi-beat burst, splits bursts
// that reach MaxBurst beats, and flushes the arbiter when the owner stalls
// too long, abandons its burst, or a foreign index wins mid-burst.
// rst_n is an asynchronous reset that is asserted while high.

module rr_lock_burst_ctrl #(
    parameter int NumIn         = 4,
    parameter int MaxBurst      = 16,
    parameter int TimeoutCycles = 256,
    parameter int IdxWidth      = $clog2(NumIn),
    parameter int CntWidth      = $clog2(MaxBurst + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en_i,
    input  logic [NumIn-1:0]    req_i,
    input  logic [NumIn-1:0]    last_i,
    input  logic                arb_req_i,
    input  logic                arb_gnt_i,
    input  logic [IdxWidth-1:0] arb_idx_i,
    output logic                lock_rr_o,
    output logic                flush_o,
    output logic [IdxWidth-1:0] owner_o,
    output logic                owner_vld_o,
    output logic [CntWidth-1:0] beat_cnt_o,
    output logic                timeout_o,
    output logic                err_o
);

    localparam int StallWidth = $clog2(TimeoutCycles);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOCKED = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

    state_t                r_state;
    logic [IdxWidth-1:0]   r_owner;
    logic [CntWidth-1:0]   r_beat_cnt;
    logic [StallWidth-1:0] r_stall;
    logic                  r_flush;
    logic                  r_timeout;
    logic                  r_err;

    logic w_hs;
    logic w_idx_last;
    logic w_owner_req;
    logic w_owner_last;
    logic w_idx_match;
    logic w_locked;
    logic w_burst_full;
    logic w_release;
    logic w_mismatch;
    logic w_abandon;
    logic w_stall_max;

    // Handshake decode and the per-cycle burst conditions seen while locked.
    assign w_hs         = arb_req_i & arb_gnt_i;
    assign w_idx_last   = last_i[arb_idx_i];
    assign w_owner_req  = req_i[r_owner];
    assign w_owner_last = last_i[r_owner];
    assign w_idx_match  = (arb_idx_i == r_owner);
    assign w_locked     = (r_state == ST_LOCKED);
    // The beat being accepted now would be beat number MaxBurst.
    assign w_burst_full = (r_beat_cnt == CntWidth'(MaxBurst - 1));
    assign w_release    = w_locked & w_hs & w_idx_match & (w_owner_last | w_burst_full);
    assign w_mismatch   = w_hs & ~w_idx_match;
    assign w_abandon    = ~w_hs & ~w_owner_req;
    assign w_stall_max  = (r_stall == StallWidth'(TimeoutCycles - 1));

    // Lock drops combinationally on the releasing beat so the arbiter's
    // round-robin pointer can advance on the final beat.
    assign lock_rr_o   = w_locked & ~w_release;
    assign flush_o     = r_flush;
    assign owner_o     = r_owner;
    assign owner_vld_o = w_locked;
    assign beat_cnt_o  = r_beat_cnt;
    assign timeout_o   = r_timeout;
    assign err_o       = r_err;

    // Burst-lock state machine with its registered flush/timeout/error pulses.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state    <= ST_IDLE;
            r_owner    <= '0;
            r_beat_cnt <= '0;
            r_stall    <= '0;
            r_flush    <= 1'b0;
            r_timeout  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            // Pulses last a single cycle unless re-armed below.
            r_flush   <= 1'b0;
            r_timeout <= 1'b0;
            r_err     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // Single-beat transfers and disabled operation never lock.
                    if (w_hs && !w_idx_last && en_i) begin
                        r_state    <= ST_LOCKED;
                        r_owner    <= arb_idx_i;
                        r_beat_cnt <= CntWidth'(1);
                        r_stall    <= '0;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_LOCKED: begin
                    if (w_mismatch || w_abandon) begin
                        // Foreign winner or abandoned burst: recover by flushing.
                        r_state <= ST_FLUSH;
                        r_flush <= 1'b1;
                        r_err   <= 1'b1;
                    end else if (w_release) begin
                        r_state    <= ST_IDLE;
                        r_beat_cnt <= '0;
                        r_stall    <= '0;
                    end else if (w_hs) begin
                        r_beat_cnt <= r_beat_cnt + CntWidth'(1);
                        r_stall    <= '0;
                    end else if (!en_i) begin
                        // Locking disabled mid-burst: drop out quietly.
                        r_state    <= ST_IDLE;
                        r_beat_cnt <= '0;
                        r_stall    <= '0;
                    end else if (w_stall_max) begin
                        r_state   <= ST_FLUSH;
                        r_flush   <= 1'b1;
                        r_timeout <= 1'b1;
                    end else begin
                        r_stall <= r_stall + StallWidth'(1);
                    end
                end
                ST_FLUSH: begin
                    r_state    <= ST_IDLE;
                    r_owner    <= '0;
                    r_beat_cnt <= '0;
                    r_stall    <= '0;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_owner    <= '0;
                    r_beat_cnt <= '0;
                    r_stall    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_lock_burst_ctrl.sv
// Self-checking bench for rr_lock_burst_ctrl: directed burst scenarios
// followed by randomized traffic, every cycle compared against a
// cycle-level reference model of the burst rules.

module tb_rr_lock_burst_ctrl;

    localparam int NumIn    = 4;
    localparam int MaxBurst = 4;
    localparam int Timeout  = 8;

    logic       clk;
    logic       rst_n;
    logic       en_i;
    logic [3:0] req_i;
    logic [3:0] last_i;
    logic       arb_req_i;
    logic       arb_gnt_i;
    logic [1:0] arb_idx_i;
    logic       lock_rr_o;
    logic       flush_o;
    logic [1:0] owner_o;
    logic       owner_vld_o;
    logic [2:0] beat_cnt_o;
    logic       timeout_o;
    logic       err_o;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: burst owner (-1 = no burst), beats taken, quiet cycles
    int m_owner;
    int m_owner_out;
    int m_beats;
    int m_quiet;
    bit m_flush;
    bit m_tmo;
    bit m_err;

    rr_lock_burst_ctrl #(
        .NumIn(NumIn),
        .MaxBurst(MaxBurst),
        .TimeoutCycles(Timeout)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en_i(en_i),
        .req_i(req_i),
        .last_i(last_i),
        .arb_req_i(arb_req_i),
        .arb_gnt_i(arb_gnt_i),
        .arb_idx_i(arb_idx_i),
        .lock_rr_o(lock_rr_o),
        .flush_o(flush_o),
        .owner_o(owner_o),
        .owner_vld_o(owner_vld_o),
        .beat_cnt_o(beat_cnt_o),
        .timeout_o(timeout_o),
        .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner     = -1;
        m_owner_out = 0;
        m_beats     = 0;
        m_quiet     = 0;
        m_flush     = 1'b0;
        m_tmo       = 1'b0;
        m_err       = 1'b0;
    endtask

    // Compare every output with the model given the inputs now applied.
    task automatic check_all(input string tag);
        bit hs;
        bit rel;
        hs  = arb_req_i & arb_gnt_i;
        rel = (m_owner >= 0) && hs && (int'(arb_idx_i) == m_owner) &&
              (last_i[m_owner] || (m_beats + 1 == MaxBurst));
        chk({tag, ".lock_rr"}, lock_rr_o, (m_owner >= 0) && !rel);
        chk({tag, ".flush"}, flush_o, m_flush);
        chk({tag, ".timeout"}, timeout_o, m_tmo);
        chk({tag, ".err"}, err_o, m_err);
        chk({tag, ".owner_vld"}, owner_vld_o, m_owner >= 0);
        chk({tag, ".owner"}, owner_o, m_owner_out);
        chk({tag, ".beat_cnt"}, beat_cnt_o, m_beats);
    endtask

    // Advance the model across one rising edge with the current inputs.
    task automatic model_step();
        bit hs;
        hs = arb_req_i & arb_gnt_i;
        if (m_flush) begin
            m_flush     = 1'b0;
            m_tmo       = 1'b0;
            m_err       = 1'b0;
            m_owner_out = 0;
            m_beats     = 0;
            m_quiet     = 0;
        end else if (m_owner < 0) begin
            if (hs && !last_i[arb_idx_i] && en_i) begin
                m_owner     = int'(arb_idx_i);
                m_owner_out = int'(arb_idx_i);
                m_beats     = 1;
                m_quiet     = 0;
            end
        end else begin
            if ((hs && int'(arb_idx_i) != m_owner) || (!hs && !req_i[m_owner])) begin
                m_flush = 1'b1;
                m_err   = 1'b1;
                m_owner = -1;
            end else if (hs && (last_i[m_owner] || (m_beats + 1 == MaxBurst))) begin
                m_owner = -1;
                m_beats = 0;
                m_quiet = 0;
            end else if (hs) begin
                m_beats++;
                m_quiet = 0;
            end else if (!en_i) begin
                m_owner = -1;
                m_beats = 0;
                m_quiet = 0;
            end else begin
                m_quiet++;
                if (m_quiet == Timeout) begin
                    m_flush = 1'b1;
                    m_tmo   = 1'b1;
                    m_owner = -1;
                end
            end
        end
    endtask

    // One clock: drive after the falling edge, check, take the rising edge.
    task automatic step(input string tag, input logic en, input logic [3:0] req,
                        input logic [3:0] last, input logic areq, input logic gnt,
                        input logic [1:0] idx);
        en_i      = en;
        req_i     = req;
        last_i    = last;
        arb_req_i = areq;
        arb_gnt_i = gnt;
        arb_idx_i = idx;
        #1;
        check_all(tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".lock_rr"}, lock_rr_o, 0);
        chk({tag, ".flush"}, flush_o, 0);
        chk({tag, ".owner"}, owner_o, 0);
        chk({tag, ".owner_vld"}, owner_vld_o, 0);
        chk({tag, ".beat_cnt"}, beat_cnt_o, 0);
        chk({tag, ".timeout"}, timeout_o, 0);
        chk({tag, ".err"}, err_o, 0);
    endtask

    initial begin
        int quiet_left;
        logic [3:0] rq;
        logic [3:0] lst;
        logic [1:0] ix;

        rst_n     = 1'b1;
        en_i      = 1'b1;
        req_i     = 4'b0000;
        last_i    = 4'b0000;
        arb_req_i = 1'b0;
        arb_gnt_i = 1'b1;
        arb_idx_i = 2'd0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b0;

        // Scenario 1: input 2, three beats, last on the third
        step("s1_b1", 1'b1, 4'b0100, 4'b0000, 1'b1, 1'b1, 2'd2);
        chk("s1_owner", owner_o, 2);
        chk("s1_cnt1", beat_cnt_o, 1);
        step("s1_b2", 1'b1, 4'b0100, 4'b0000, 1'b1, 1'b1, 2'd2);
        chk("s1_cnt2", beat_cnt_o, 2);
        step("s1_b3", 1'b1, 4'b0100, 4'b0100, 1'b1, 1'b1, 2'd2);
        chk("s1_idle", owner_vld_o, 0);
        step("s1_gap", 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd0);

        // Scenario 2: input 1, six beats without last, split after four
        for (int i = 0; i < 6; i++)
            step("s2_beat", 1'b1, 4'b0010, 4'b0000, 1'b1, 1'b1, 2'd1);
        chk("s2_cnt_new", beat_cnt_o, 2);
        step("s2_end", 1'b1, 4'b0010, 4'b0010, 1'b1, 1'b1, 2'd1);
        step("s2_gap", 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd0);

        // Scenario 3: lock on input 0, then stall until the watchdog fires
        step("s3_b1", 1'b1, 4'b0001, 4'b0000, 1'b1, 1'b1, 2'd0);
        for (int i = 0; i < Timeout; i++)
            step("s3_stall", 1'b1, 4'b0001, 4'b0000, 1'b0, 1'b1, 2'd0);
        chk("s3_timeout", timeout_o, 1);
        chk("s3_flush", flush_o, 1);
        step("s3_flushcyc", 1'b1, 4'b0001, 4'b0000, 1'b0, 1'b1, 2'd0);
        chk("s3_after_vld", owner_vld_o, 0);
        chk("s3_after_flush", flush_o, 0);

        // Scenario 4: lock on input 3, requester abandons the burst
        step("s4_b1", 1'b1, 4'b1000, 4'b0000, 1'b1, 1'b1, 2'd3);
        step("s4_drop", 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd3);
        chk("s4_err", err_o, 1);
        chk("s4_flush", flush_o, 1);
        step("s4_flushcyc", 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd0);
        chk("s4_idle", owner_vld_o, 0);

        // Scenario 5: single-beat transfer, then en_i low mid-burst
        step("s5_single", 1'b1, 4'b0100, 4'b0100, 1'b1, 1'b1, 2'd2);
        chk("s5_single_idle", owner_vld_o, 0);
        step("s5_b1", 1'b1, 4'b0010, 4'b0000, 1'b1, 1'b1, 2'd1);
        step("s5_dis", 1'b0, 4'b0010, 4'b0000, 1'b0, 1'b1, 2'd1);
        chk("s5_dis_idle", owner_vld_o, 0);
        chk("s5_dis_noflush", flush_o, 0);
        step("s5_dis_hold", 1'b0, 4'b0010, 4'b0000, 1'b1, 1'b1, 2'd1);
        chk("s5_dis_nolock", owner_vld_o, 0);

        // Scenario 6: reset at beat 2 of a locked burst
        step("s6_b1", 1'b1, 4'b0001, 4'b0000, 1'b1, 1'b1, 2'd0);
        #2;
        rst_n = 1'b1;
        #1;
        check_zero("s6_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b0;
        step("s6_fresh", 1'b1, 4'b0001, 4'b0000, 1'b1, 1'b1, 2'd0);
        chk("s6_fresh_cnt", beat_cnt_o, 1);
        step("s6_end", 1'b1, 4'b0001, 4'b0001, 1'b1, 1'b1, 2'd0);

        // Randomized traffic
        quiet_left = 0;
        for (int i = 0; i < 800; i++) begin
            rq  = 4'($urandom_range(0, 15));
            lst = 4'b0000;
            for (int b = 0; b < NumIn; b++)
                lst[b] = ($urandom_range(0, 3) == 0);
            if (m_owner >= 0 && $urandom_range(0, 9) < 8)
                ix = 2'(m_owner);
            else
                ix = 2'($urandom_range(0, 3));
            if (m_owner >= 0 && $urandom_range(0, 7) != 0)
                rq[m_owner] = 1'b1;
            if (m_owner >= 0 && quiet_left == 0 && $urandom_range(0, 39) == 0)
                quiet_left = 9;
            if (quiet_left > 0) begin
                quiet_left--;
                if (m_owner >= 0)
                    rq[m_owner] = 1'b1;
                step("rnd_quiet", 1'b1, rq, lst, 1'b0, 1'b1, ix);
            end else begin
                step("rnd", ($urandom_range(0, 15) != 0), rq, lst,
                     ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) != 0), ix);
            end
        end
        #1;
        check_all("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
